pattern_sched: RTL and testbench

Round-robin scheduler that shares one 2-bit Moore pattern detector among NUM_REQ symbol-stream requesters. It grants a single requester per burst and clears the detector before the burst. It then forwards the burst's symbols to the detector, watches the detector's output for the 2'b10 "01-then-10" hit code, and returns one response per burst. It sits between the requester front-ends and the detector instance. It owns the detector's `in` and `reset` pins.

---
 rtl/pattern_sched_if.sv | 33 +++
 rtl/pattern_sched.sv | 136 +++++++++++++
 tb/tb_pattern_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_sched_if.sv
// Requester, detector and response signals of pattern_sched bundled in one interface.
// slave = the scheduler's view; master = requesters, detector and response sink.
interface pattern_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 8
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_sym;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [1:0]           det_in;
  logic                 det_reset;
  logic [1:0]           det_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic                 rsp_hit;
  logic [CW-1:0]        rsp_count;
  logic                 rsp_abort;

  modport slave (
    input  req_valid, req_sym, req_last, det_out, rsp_ready,
    output req_ready, det_in, det_reset, rsp_valid, rsp_id, rsp_hit, rsp_count, rsp_abort
  );

  modport master (
    output req_valid, req_sym, req_last, det_out, rsp_ready,
    input  req_ready, det_in, det_reset, rsp_valid, rsp_id, rsp_hit, rsp_count, rsp_abort
  );
endinterface

// File: rtl/pattern_sched.sv
// Round-robin scheduler sharing one 01->10 Moore detector among NUM_REQ symbol streams.
// Optional stall timeout enabled by defining PATSCHED_TIMEOUT_EN.
module pattern_sched #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 8
) (
  input  logic            clk,
  input  logic            reset,
  pattern_sched_if.slave  bus
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]               state, state_nxt;
  logic [IW-1:0]            grant, rr_ptr, pick;
  logic [IW:0]              cand;
  logic                     found;
  logic                     hit;
  logic [CW-1:0]            count;
  logic                     abort;
  logic                     timeout;
  logic [NUM_REQ-1:0][1:0]  sym;
  logic                     g_valid, g_last, xfer, at_max;
  logic [1:0]               g_sym;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign sym[i] = bus.req_sym[2*i +: 2];
  end

  assign g_valid = bus.req_valid[grant];
  assign g_last  = bus.req_last[grant];
  assign g_sym   = sym[grant];
  assign xfer    = (state == STREAM) && g_valid;
  assign at_max  = (count == CW'(MAX_LEN - 1));

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && bus.req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if ((xfer && (g_last || at_max)) || timeout) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      hit    <= 1'b0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          hit   <= 1'b0;
          count <= '0;
          if (found) grant <= pick;
        end
        STREAM: begin
          if (xfer) count <= count + 1'b1;
          if (bus.det_out == 2'b10) hit <= 1'b1;
        end
        // last symbol's Moore output only shows up here
        DRAIN: if (bus.det_out == 2'b10) hit <= 1'b1;
        DONE:  if (bus.rsp_ready) rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PATSCHED_TIMEOUT_EN
  logic [3:0] stall;

  // 15th consecutive idle STREAM cycle ends the burst
  assign timeout = (state == STREAM) && !g_valid && (stall == 4'd14);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall <= '0;
      abort <= 1'b0;
    end else begin
      if (state != STREAM || g_valid) stall <= '0;
      else                            stall <= stall + 1'b1;
      if (state == IDLE)  abort <= 1'b0;
      else if (timeout)   abort <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
`endif

  always_comb begin
    bus.req_ready = '0;
    if (state == STREAM) bus.req_ready[grant] = 1'b1;
  end

  assign bus.det_in    = xfer ? g_sym : 2'b00;
  assign bus.det_reset = (state == CLEAR);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_id    = grant;
  assign bus.rsp_hit   = hit;
  assign bus.rsp_count = count;
  assign bus.rsp_abort = abort;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.req_ready));
  a_det_quiet:    assert property (@(posedge clk) disable iff (!reset) !xfer |-> bus.det_in == 2'b00);
  a_rsp_hold:     assert property (@(posedge clk) disable iff (!reset)
                    bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid &&
                    $stable({bus.rsp_id, bus.rsp_hit, bus.rsp_count, bus.rsp_abort}));
endmodule

// File: tb/tb_pattern_sched.sv
// Self-checking bench for pattern_sched: behavioural detector, per-requester queues,
// burst-level reference model, vector table and hand sequences for timing corners.
module tb_pattern_sched;
  localparam int NUM_REQ = 4;
  localparam int MAX_LEN = 8;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(NUM_REQ);

  logic clk = 1'b0;
  logic reset;

  pattern_sched_if #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN)) bus();
  pattern_sched #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [1:0] sym; bit last; int gap; } item_t;
  typedef struct { int id; bit hit; int count; bit abort; } rsp_t;
  typedef struct { int id; int n; logic [1:0] s[4]; int g[4]; bit hit; int cnt; } vec_t;

  item_t q  [NUM_REQ][$];
  rsp_t  bq [NUM_REQ][$];
  rsp_t  expq[$];
  vec_t  tbl[9];

  int  vecs = 0, errs = 0, nrsp = 0;
  bit  auto_drv = 0, rnd_ready = 0, held = 0;
  logic [IW+CW+1:0] snap;
  logic [1:0] dh1 = 2'b00, dh0 = 2'b00;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [IW+CW+1:0] rsp_word();
    return {bus.rsp_id, bus.rsp_hit, bus.rsp_count, bus.rsp_abort};
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() > 0 && q[i][0].gap == 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_sym[2*i +: 2]  = q[i][0].sym;
        bus.req_last[i]        = q[i][0].last;
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_sym[2*i +: 2]  = 2'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
    end
    bus.rsp_ready = rnd_ready ? 1'($urandom) : 1'b1;
  endtask

  // advance one clock; detector and queues update from pre-edge values
  task automatic adv();
    logic [1:0] din;
    logic drst;
    logic [NUM_REQ-1:0] rdy, vld;
    din = bus.det_in; drst = bus.det_reset; rdy = bus.req_ready; vld = bus.req_valid;
    @(posedge clk);
    @(negedge clk);
    if (drst) begin dh1 = 2'b00; dh0 = 2'b00; end
    else      begin dh1 = dh0;   dh0 = din;   end
    bus.det_out = (dh1 == 2'b01 && dh0 == 2'b10) ? 2'b10 : 2'b00;
    if (auto_drv)
      for (int i = 0; i < NUM_REQ; i++)
        if (q[i].size() > 0 && rdy[i]) begin
          if (vld[i])               q[i].delete(0);
          else if (q[i][0].gap > 0) q[i][0].gap = q[i][0].gap - 1;
        end
  endtask

  task automatic mon();
    rsp_t e;
    if (bus.rsp_valid) begin
      if (held) chk("rsp_stable", int'(rsp_word()), int'(snap));
      if (bus.rsp_ready) begin
        held = 0;
        nrsp++;
        if (expq.size() == 0) chk("rsp_unexpected", int'(bus.rsp_valid), 0);
        else begin
          e = expq.pop_front();
          chk("rsp_id",    int'(bus.rsp_id),    e.id);
          chk("rsp_hit",   int'(bus.rsp_hit),   int'(e.hit));
          chk("rsp_count", int'(bus.rsp_count), e.count);
          chk("rsp_abort", int'(bus.rsp_abort), int'(e.abort));
        end
      end else begin
        held = 1;
        snap = rsp_word();
      end
    end else held = 0;
  endtask

  task automatic step();
    drive();
    #1;
    mon();
    adv();
  endtask

  task automatic run_until(input int target, input int budget);
    int b;
    b = budget;
    while (nrsp < target && b > 0) begin step(); b--; end
    chk("responses_seen", nrsp, target);
  endtask

  // queue a requester's items; model splits into bursts (last or MAX_LEN) and
  // finds 01-then-10 in the symbol stream the detector sees (stall cycles feed 00)
  task automatic load_req(input int id, input item_t items[$], input int mode);
    int cnt;
    logic [1:0] st[$];
    rsp_t r;
    cnt = 0;
    foreach (items[k]) begin
      if (cnt == 0) items[k].gap = 0;
      else for (int z = 0; z < items[k].gap; z++) st.push_back(2'b00);
      st.push_back(items[k].sym);
      cnt++;
      if (items[k].last || cnt == MAX_LEN) begin
        r.id = id; r.count = cnt; r.abort = 0; r.hit = 0;
        for (int j = 0; j + 1 < st.size(); j++)
          if (st[j] == 2'b01 && st[j+1] == 2'b10) r.hit = 1;
        if (mode == 0) bq[id].push_back(r);
        else if (mode == 1) expq.push_back(r);
        cnt = 0;
        st.delete();
      end
      q[id].push_back(items[k]);
    end
  endtask

  task automatic push_exp(input int id, input bit hit, input int count, input bit abort);
    rsp_t r;
    r.id = id; r.hit = hit; r.count = count; r.abort = abort;
    expq.push_back(r);
  endtask

  task automatic do_reset();
    auto_drv = 0; held = 0; rnd_ready = 0;
    for (int i = 0; i < NUM_REQ; i++) begin q[i].delete(); bq[i].delete(); end
    expq.delete();
    reset = 1'b0;
    bus.req_valid = '0; bus.req_sym = '0; bus.req_last = '0;
    bus.rsp_ready = 1'b1; bus.det_out = 2'b00;
    dh1 = 2'b00; dh0 = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
    chk({tag, "_det_in"},    int'(bus.det_in),    0);
    chk({tag, "_det_reset"}, int'(bus.det_reset), 0);
    chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({tag, "_rsp_word"},  int'(rsp_word()),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t tmp[$];
    int p, g, n;

    tbl[0] = '{0, 3, '{2'b01, 2'b10, 2'b11, 2'b00}, '{0, 0, 0, 0}, 1, 3};
    tbl[1] = '{2, 3, '{2'b01, 2'b00, 2'b10, 2'b00}, '{0, 0, 0, 0}, 0, 3};
    tbl[2] = '{1, 2, '{2'b01, 2'b10, 2'b00, 2'b00}, '{0, 1, 0, 0}, 0, 2};
    tbl[3] = '{3, 4, '{2'b11, 2'b01, 2'b10, 2'b00}, '{0, 0, 0, 0}, 1, 4};
    tbl[4] = '{1, 2, '{2'b10, 2'b01, 2'b00, 2'b00}, '{0, 0, 0, 0}, 0, 2};
    tbl[5] = '{0, 1, '{2'b01, 2'b00, 2'b00, 2'b00}, '{0, 0, 0, 0}, 0, 1};
    tbl[6] = '{2, 4, '{2'b01, 2'b01, 2'b01, 2'b10}, '{0, 0, 0, 0}, 1, 4};
    tbl[7] = '{3, 3, '{2'b01, 2'b11, 2'b10, 2'b00}, '{0, 2, 0, 0}, 0, 3};
    tbl[8] = '{0, 3, '{2'b01, 2'b10, 2'b00, 2'b00}, '{0, 0, 3, 0}, 1, 3};

    // reset values, with requests pending to show they are gated
    reset = 1'b0;
    bus.req_valid = '1; bus.req_sym = '1; bus.req_last = '0;
    bus.rsp_ready = 1'b1; bus.det_out = 2'b00;
    @(negedge clk); @(negedge clk); #1;
    chk_reset_outs("reset");

    // cycle-accurate walk of req 0 burst 01,10,11
    do_reset();
    bus.req_valid = 4'b0001; bus.req_sym[1:0] = 2'b01; bus.req_last = '0;
    #1; chk("a0_ready", int'(bus.req_ready), 0); chk("a0_det_reset", int'(bus.det_reset), 0); adv();
    #1; chk("a1_det_reset", int'(bus.det_reset), 1); chk("a1_det_in", int'(bus.det_in), 0);
        chk("a1_ready", int'(bus.req_ready), 0); adv();
    #1; chk("a2_ready", int'(bus.req_ready), 1); chk("a2_det_in", int'(bus.det_in), 1);
        chk("a2_det_reset", int'(bus.det_reset), 0); adv();
    bus.req_sym[1:0] = 2'b10;
    #1; chk("a3_det_in", int'(bus.det_in), 2); adv();
    bus.req_sym[1:0] = 2'b11; bus.req_last[0] = 1'b1;
    #1; chk("a4_det_in", int'(bus.det_in), 3); adv();
    bus.req_valid = '0; bus.req_last = '0;
    #1; chk("a5_det_in", int'(bus.det_in), 0); chk("a5_rsp_valid", int'(bus.rsp_valid), 0);
        chk("a5_ready", int'(bus.req_ready), 0); adv();
    #1; chk("a6_rsp_valid", int'(bus.rsp_valid), 1); chk("a6_id", int'(bus.rsp_id), 0);
        chk("a6_hit", int'(bus.rsp_hit), 1); chk("a6_count", int'(bus.rsp_count), 3);
        chk("a6_abort", int'(bus.rsp_abort), 0); adv();
    #1; chk("a7_rsp_valid", int'(bus.rsp_valid), 0); adv();

    // vector table, one burst per record
    auto_drv = 1;
    for (int v = 0; v < 9; v++) begin
      tmp.delete();
      for (int k = 0; k < tbl[v].n; k++)
        tmp.push_back('{tbl[v].s[k], (k == tbl[v].n - 1), tbl[v].g[k]});
      load_req(tbl[v].id, tmp, 2);
      push_exp(tbl[v].id, tbl[v].hit, tbl[v].cnt, 0);
      run_until(nrsp + 1, 60);
    end

    // round robin: 0 and 3 together, 0 re-requests during 3's burst
    do_reset();
    auto_drv = 1;
    tmp.delete(); tmp.push_back('{2'b01, 1, 0}); load_req(0, tmp, 2);
    tmp.delete(); tmp.push_back('{2'b11, 0, 0}); tmp.push_back('{2'b01, 0, 0});
    tmp.push_back('{2'b10, 1, 0}); load_req(3, tmp, 2);
    push_exp(0, 0, 1, 0); push_exp(3, 1, 3, 0); push_exp(0, 0, 1, 0);
    run_until(nrsp + 1, 40);
    tmp.delete(); tmp.push_back('{2'b10, 1, 0}); load_req(0, tmp, 2);
    run_until(nrsp + 2, 60);

    // MAX_LEN truncation: 9 symbols, last only on the 9th
    tmp.delete();
    for (int k = 0; k < 7; k++) tmp.push_back('{2'b11, 0, 0});
    tmp.push_back('{2'b01, 0, 0}); tmp.push_back('{2'b10, 1, 0});
    load_req(1, tmp, 2);
    push_exp(1, 0, 8, 0); push_exp(1, 0, 1, 0);
    run_until(nrsp + 2, 80);

    // 15-cycle stall after the first symbol
    tmp.delete(); tmp.push_back('{2'b01, 0, 0}); tmp.push_back('{2'b10, 1, 15});
    load_req(0, tmp, 2);
`ifdef PATSCHED_TIMEOUT_EN
    push_exp(0, 0, 1, 1); push_exp(0, 0, 1, 0);
    run_until(nrsp + 2, 80);
`else
    push_exp(0, 0, 2, 0);
    run_until(nrsp + 1, 80);
`endif

    // reset mid-STREAM drops the burst
    do_reset();
    bus.req_valid = 4'b0100; bus.req_sym[5:4] = 2'b01; bus.req_last = '0;
    #1; adv();
    #1; adv();
    #1; chk("e_ready_stream", int'(bus.req_ready), 4);
    #2; reset = 1'b0;
    #1; chk_reset_outs("e_mid");
    bus.req_valid = '0;
    adv();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1; chk("e_no_rsp", int'(bus.rsp_valid), 0);
      adv();
    end

    // randomized rounds against the burst-level model
    for (int round = 0; round < 4; round++) begin
      do_reset();
      auto_drv = 1;
      rnd_ready = 1;
      for (int i = 0; i < NUM_REQ; i++) begin
        tmp.delete();
        n = $urandom_range(1, 12);
        for (int k = 0; k < n; k++)
          tmp.push_back('{2'($urandom), (k == n - 1) || ($urandom_range(0, 3) == 0),
                         int'($urandom_range(0, 2))});
        load_req(i, tmp, 0);
      end
      p = 0;
      forever begin
        g = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && bq[(p + k) % NUM_REQ].size() > 0) g = (p + k) % NUM_REQ;
        if (g < 0) break;
        expq.push_back(bq[g].pop_front());
        p = (g + 1) % NUM_REQ;
      end
      run_until(nrsp + expq.size(), 3000);
      chk("exp_left", expq.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
